hilo_div_unit: RTL and testbench
================================

Name: hilo_div_unit

Overview:
- Iterative signed/unsigned 32-bit divider that owns the HI/LO register pair in the EX stage.
- Consumes the isDiv / ismfhi strobes produced by ALU control decoding. Executes DIV/DIVU over multiple cycles and serves MFHI/MFLO reads.
- Raises a stall to the pipeline hazard logic while a division is in flight.

Parameters:
- WIDTH, 32, operand/HI/LO width.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- div_start  in  1  isDiv qualified by a valid EX instruction; one-cycle strobe.
- div_signed  in  1  1 = DIV (signed), 0 = DIVU.
- dividend  in  WIDTH  rs operand, sampled with div_start.
- divisor  in  WIDTH  rt operand, sampled with div_start.
- rd_en  in  1  MFHI/MFLO in EX.
- rd_hi  in  1  1 = read HI (ismfhi), 0 = read LO.
- rd_data  out  WIDTH  selected HI or LO; combinational from the registers.
- busy  out  1  division in flight.
- stall  out  1  = busy & (div_start | rd_en).
- done  out  1  one-cycle pulse when HI/LO are updated.
- div_zero  out  1  last division had divisor == 0; holds until the next accepted start.
- hi  out  WIDTH  HI register (remainder).
- lo  out  WIDTH  LO register (quotient).

Behaviour:
- Reset:
  - state = IDLE; hi = lo = 0.
  - busy = done = div_zero = 0; counter = 0.
  - Reset mid-division aborts it and no HI/LO write occurs.
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - div_start = 1 accepts the operands and latches the operand signs.
  - For DIV, magnitudes are taken: |x| of 0x80000000 stays 0x80000000, treated as unsigned.
  - divisor != 0: go to CALC, counter = 0, partial remainder = 0, quotient shift register = |dividend|.
  - divisor == 0: go to FIX with quotient = 0xFFFFFFFF, remainder = dividend (raw); div_zero set at the FIX edge.
- CALC:
  - One restoring radix-2 step per cycle: shift {rem, quot} left by 1, trial subtract |divisor|, and if no borrow keep the difference and set quot[0] = 1.
  - Exactly WIDTH cycles; after counter reaches WIDTH-1, go to FIX.
- FIX:
  - Signed op: negate quotient if sign(dividend) ^ sign(divisor); negate remainder if sign(dividend). Unsigned op: no correction.
  - On this edge: write hi = remainder, lo = quotient; go to DONE.
- DONE:
  - done = 1 for exactly this one cycle; go to IDLE.
  - A div_start in DONE is accepted exactly as in IDLE.
- busy = 1 in CALC and FIX; 0 in IDLE and DONE.
- Latency:
  - Start edge E0. HI/LO hold new values from edge E0+WIDTH+1, i.e. visible in cycle 34 for WIDTH = 32; done is high in that cycle.
  - Divide-by-zero: HI/LO are visible after edge E0+1.
- Stall/hazard:
  - While busy, div_start is ignored (not latched) and stall = 1; upstream holds the instruction and reissues it.
  - While busy, rd_en drives stall = 1; rd_data shows the old HI/LO and must not be consumed until stall drops.
  - stall is combinational with no registered delay.
- rd_data:
  - = rd_hi ? hi : lo, regardless of rd_en.
  - A read in the DONE cycle returns the new values.
- Overflow: DIV 0x80000000 / 0xFFFFFFFF gives lo = 0x80000000, hi = 0 (wrap, no trap).
- Outputs hi/lo change only at FIX edges or reset.

Test Plan:
- DIVU 100 / 7 → after 34 cycles done = 1, lo = 14, hi = 2, div_zero = 0; busy high for exactly 33 cycles starting the cycle after start.
- DIV −100 (0xFFFFFF9C) / 7 → lo = 0xFFFFFFF2 (−14), hi = 0xFFFFFFFE (−2). DIV 100 / −7 → lo = −14, hi = 2.
- DIV 0x80000000 / 0xFFFFFFFF → lo = 0x80000000, hi = 0. DIVU 0xFFFFFFFF / 1 → lo = 0xFFFFFFFF, hi = 0.
- DIVU 55 / 0 → div_zero = 1, lo = 0xFFFFFFFF, hi = 55, done two cycles after the start edge; the next valid start clears div_zero at its FIX edge.
- Hazard check:
  - Assert rd_en with rd_hi = 1 at cycle 5 of a division → stall = 1 until the DONE cycle, then rd_data = new hi.
  - Assert div_start at cycle 10 → ignored, stall = 1; HI/LO reflect only the first division.
- Reset asserted at cycle 20 of a division → next cycle busy = 0, done = 0, hi = lo = 0; no done pulse ever appears for the aborted op.

Source files
------------

// File: rtl/hilo_div_unit.sv
// HI/LO register pair with an iterative restoring divider for DIV/DIVU.
// Serves MFHI/MFLO reads and stalls the pipeline while a division is in flight.
module hilo_div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             div_start,
  input  logic             div_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             rd_en,
  input  logic             rd_hi,
  output logic [WIDTH-1:0] rd_data,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             neg_quot_q, neg_quot_d;
  logic             neg_rem_q, neg_rem_d;
  logic             dz_op_q, dz_op_d;
  logic             div_zero_q, div_zero_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic [WIDTH:0]   shifted_s;
  logic             ge_s;
  logic             accept_s;

  // Two's-complement negate; magnitude of the most negative value wraps to itself.
  function automatic logic [WIDTH-1:0] neg(input logic [WIDTH-1:0] x);
    return ~x + WIDTH'(1);
  endfunction

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x, input logic sgn);
    return (sgn && x[WIDTH-1]) ? neg(x) : x;
  endfunction

  assign shifted_s = {rem_q, quot_q[WIDTH-1]};
  assign ge_s      = (shifted_s >= {1'b0, dvs_q});
  assign accept_s  = div_start && ((state_q == S_IDLE) || (state_q == S_DONE));

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rem_d      = rem_q;
    quot_d     = quot_q;
    dvs_d      = dvs_q;
    neg_quot_d = neg_quot_q;
    neg_rem_d  = neg_rem_q;
    dz_op_d    = dz_op_q;
    div_zero_d = div_zero_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (accept_s) begin
          if (divisor == '0) begin
            // Divide-by-zero bypasses iteration and sign fix-up: raw dividend to HI.
            state_d    = S_FIX;
            quot_d     = '1;
            rem_d      = dividend;
            neg_quot_d = 1'b0;
            neg_rem_d  = 1'b0;
            dz_op_d    = 1'b1;
          end else begin
            state_d    = S_CALC;
            cnt_d      = '0;
            rem_d      = '0;
            quot_d     = mag(dividend, div_signed);
            dvs_d      = mag(divisor, div_signed);
            neg_quot_d = div_signed && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            neg_rem_d  = div_signed && dividend[WIDTH-1];
            dz_op_d    = 1'b0;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CALC: begin
        quot_d = {quot_q[WIDTH-2:0], ge_s};
        rem_d  = ge_s ? (shifted_s[WIDTH-1:0] - dvs_q) : shifted_s[WIDTH-1:0];
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH-1)) begin
          state_d = S_FIX;
        end else begin
          state_d = S_CALC;
        end
      end
      S_FIX: begin
        lo_d       = neg_quot_q ? neg(quot_q) : quot_q;
        hi_d       = neg_rem_q ? neg(rem_q) : rem_q;
        div_zero_d = dz_op_q;
        state_d    = S_DONE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      rem_q      <= '0;
      quot_q     <= '0;
      dvs_q      <= '0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      dz_op_q    <= 1'b0;
      div_zero_q <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rem_q      <= rem_d;
      quot_q     <= quot_d;
      dvs_q      <= dvs_d;
      neg_quot_q <= neg_quot_d;
      neg_rem_q  <= neg_rem_d;
      dz_op_q    <= dz_op_d;
      div_zero_q <= div_zero_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
    end
  end

  assign busy     = (state_q == S_CALC) || (state_q == S_FIX);
  assign done     = (state_q == S_DONE);
  assign stall    = busy && (div_start || rd_en);
  assign div_zero = div_zero_q;
  assign hi       = hi_q;
  assign lo       = lo_q;
  assign rd_data  = rd_hi ? hi_q : lo_q;

endmodule

// File: tb/tb_hilo_div_unit.sv
// Table-driven bench for hilo_div_unit with a scoreboard queue and
// hand-written hazard, divide-by-zero and reset-abort sequences.
module tb_hilo_div_unit;

  logic        clock = 1'b0;
  logic        reset, div_start, div_signed, rd_en, rd_hi;
  logic [31:0] dividend, divisor, rd_data, hi, lo;
  logic        busy, stall, done, div_zero;

  hilo_div_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clock(clock), .reset(reset), .div_start(div_start), .div_signed(div_signed),
    .dividend(dividend), .divisor(divisor), .rd_en(rd_en), .rd_hi(rd_hi),
    .rd_data(rd_data), .busy(busy), .stall(stall), .done(done),
    .div_zero(div_zero), .hi(hi), .lo(lo)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] lo;
    logic [31:0] hi;
    logic        dz;
  } vec_t;

  typedef struct {
    logic [31:0] lo;
    logic [31:0] hi;
    logic        dz;
    int          lat;
    int          bcnt;
  } exp_t;

  localparam int NVEC = 15;
  vec_t vecs [NVEC];
  exp_t sb [$];
  exp_t e;

  int n_vec  = 0;
  int n_miss = 0;
  logic [31:0] last_hi;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    if (act !== exp_v) begin
      $display("FAIL %s: got %h, expected %h", name, act, exp_v);
      n_miss++;
    end
  endtask

  task automatic start_op(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    div_signed = sgn;
    dividend   = a;
    divisor    = b;
    div_start  = 1'b1;
    tick();
    div_start  = 1'b0;
    n_vec++;
  endtask

  task automatic wait_done(output int lat, output int bcnt);
    lat  = 0;
    bcnt = 0;
    while (!done && lat < 60) begin
      if (busy) bcnt++;
      tick();
      lat++;
    end
    if (!done) begin
      $display("FAIL done_timeout: got no done, expected done within 60 cycles");
      n_miss++;
    end
  endtask

  initial begin
    int lat, bcnt;
    reset = 1'b1; div_start = 1'b0; div_signed = 1'b0; rd_en = 1'b0; rd_hi = 1'b0;
    dividend = 32'd0; divisor = 32'd0;
    vecs[0]  = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0};
    vecs[1]  = '{1'b1, 32'hFFFFFF9C,   32'd7,          32'hFFFFFFF2,   32'hFFFFFFFE,   1'b0};
    vecs[2]  = '{1'b1, 32'd100,        32'hFFFFFFF9,   32'hFFFFFFF2,   32'd2,          1'b0};
    vecs[3]  = '{1'b1, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'd0,          1'b0};
    vecs[4]  = '{1'b0, 32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   32'd0,          1'b0};
    vecs[5]  = '{1'b0, 32'd55,         32'd0,          32'hFFFFFFFF,   32'd55,         1'b1};
    vecs[6]  = '{1'b1, 32'hFFFFFF9C,   32'hFFFFFFF9,   32'd14,         32'hFFFFFFFE,   1'b0};
    vecs[7]  = '{1'b0, 32'h80000000,   32'hFFFFFFFF,   32'd0,          32'h80000000,   1'b0};
    vecs[8]  = '{1'b1, 32'hFFFFFFF9,   32'd0,          32'hFFFFFFFF,   32'hFFFFFFF9,   1'b1};
    vecs[9]  = '{1'b0, 32'd12345678,   32'd1000,       32'd12345,      32'd678,        1'b0};
    for (int i = 10; i < NVEC; i++) begin
      vecs[i].sgn = 1'b0;
      vecs[i].a   = $urandom;
      vecs[i].b   = $urandom_range(1, 65535);
      vecs[i].lo  = vecs[i].a / vecs[i].b;
      vecs[i].hi  = vecs[i].a % vecs[i].b;
      vecs[i].dz  = 1'b0;
    end

    tick(); tick(); tick();
    reset = 1'b0;
    chk("reset_hi", hi, 32'd0);
    chk("reset_lo", lo, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_div_zero", {31'd0, div_zero}, 32'd0);
    chk("reset_stall", {31'd0, stall}, 32'd0);

    // Table: each start is driven in the previous op's DONE cycle.
    for (int i = 0; i < NVEC; i++) begin
      e.lo   = vecs[i].lo;
      e.hi   = vecs[i].hi;
      e.dz   = vecs[i].dz;
      e.lat  = (vecs[i].b == 32'd0) ? 1 : 33;
      e.bcnt = (vecs[i].b == 32'd0) ? 1 : 33;
      sb.push_back(e);
      start_op(vecs[i].sgn, vecs[i].a, vecs[i].b);
      wait_done(lat, bcnt);
      if (sb.size() == 0) begin
        $display("FAIL scoreboard_empty: got done, expected none pending");
        n_miss++;
      end else begin
        e = sb.pop_front();
        chk($sformatf("v%0d_lo", i), lo, e.lo);
        chk($sformatf("v%0d_hi", i), hi, e.hi);
        chk($sformatf("v%0d_div_zero", i), {31'd0, div_zero}, {31'd0, e.dz});
        chk($sformatf("v%0d_latency", i), lat, e.lat);
        chk($sformatf("v%0d_busy_cycles", i), bcnt, e.bcnt);
        rd_hi = 1'b1; #1;
        chk($sformatf("v%0d_rd_hi", i), rd_data, e.hi);
        rd_hi = 1'b0; #1;
        chk($sformatf("v%0d_rd_lo", i), rd_data, e.lo);
        last_hi = e.hi;
      end
    end
    tick();

    // Hazard: MFHI from cycle 5, ignored re-issue of DIV at cycle 10.
    start_op(1'b0, 32'd1000, 32'd3);
    lat = 0;
    while (!done && lat < 60) begin
      rd_en     = (lat >= 5) && (lat != 10);
      rd_hi     = 1'b1;
      div_start = (lat == 10);
      dividend  = 32'd77;
      divisor   = 32'd5;
      #1;
      if (lat >= 5) begin
        chk($sformatf("hz_stall_c%0d", lat), {31'd0, stall}, 32'd1);
        chk($sformatf("hz_old_hi_c%0d", lat), rd_data, last_hi);
      end
      tick();
      lat++;
    end
    div_start = 1'b0;
    chk("hz_latency", lat, 33);
    #1;
    chk("hz_stall_done", {31'd0, stall}, 32'd0);
    chk("hz_rd_new_hi", rd_data, 32'd1);
    chk("hz_lo", lo, 32'd333);
    rd_en = 1'b0;
    tick();
    chk("hz_ignored_start_busy", {31'd0, busy}, 32'd0);
    chk("hz_ignored_start_hi", hi, 32'd1);
    tick();

    // div_zero holds through the next division and clears at its FIX edge.
    start_op(1'b0, 32'd55, 32'd0);
    wait_done(lat, bcnt);
    chk("dz_flag", {31'd0, div_zero}, 32'd1);
    chk("dz_latency", lat, 1);
    tick();
    start_op(1'b0, 32'd100, 32'd7);
    for (int k = 0; k < 10; k++) tick();
    chk("dz_hold_mid_div", {31'd0, div_zero}, 32'd1);
    wait_done(lat, bcnt);
    chk("dz_cleared", {31'd0, div_zero}, 32'd0);
    chk("dz_next_lo", lo, 32'd14);
    tick();

    // Reset abort at cycle 20 of a division.
    start_op(1'b1, 32'hFFFFFF9C, 32'd7);
    for (int k = 0; k < 20; k++) tick();
    chk("abort_busy_before", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    tick();
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_hi", hi, 32'd0);
    chk("abort_lo", lo, 32'd0);
    reset = 1'b0;
    bcnt = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (done) bcnt++;
    end
    chk("abort_no_done", bcnt, 0);
    chk("abort_hi_after", hi, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
